watch_time_writer: RTL and testbench

Timekeeping and frame-writer stage feeding the eight-digit seven-segment display slave. Counts 24-hour time (HH:MM:SS, BCD) from a clock-cycle prescaler and accepts set-mode hour/minute increments. Encodes the time as eight segment bytes plus a blink mask. Pushes each changed frame to the display slave as nine Avalon-MM master writes: addresses 0–7 are digits, address 8 is the blink mask.

---
 rtl/watch_time_writer.sv | 148 ++++++++++++++
 tb/tb_watch_time_writer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/watch_time_writer.sv
// 24-hour BCD timekeeper with set mode; pushes each changed display frame to the
// eight-digit seven-segment slave as nine Avalon-MM writes (digits 0-7, blink mask 8).
module watch_time_writer #(
  parameter int unsigned TICKS_PER_SEC  = 50000000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        set_mode,
  input  logic        inc_hour,
  input  logic        inc_min,
  output logic [3:0]  master_address,
  output logic        master_write,
  output logic [7:0]  master_writedata,
  input  logic        master_waitrequest,
  output logic        busy,
  output logic [23:0] time_bcd
);

  localparam int unsigned   CntW    = $clog2(TICKS_PER_SEC);
  localparam logic [CntW-1:0] CntLast = CntW'(TICKS_PER_SEC - 1);
  localparam logic [7:0]    Dash    = SEG_ACTIVE_LOW ? 8'hBF : 8'h40;

  typedef enum logic {StIdle, StWrite} state_e;

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [7:0]       hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic             mode_q;
  logic             dirty_q, dirty_d;
  state_e           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [8:0][7:0]  frame_q, frame_d;
  logic             snap;

  // Two-digit BCD increment that wraps to 00 after `last`.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    if (v == last)          return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] seg(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'h3F;
      4'd1:    s = 8'h06;
      4'd2:    s = 8'h5B;
      4'd3:    s = 8'h4F;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'h6D;
      4'd6:    s = 8'h7D;
      4'd7:    s = 8'h07;
      4'd8:    s = 8'h7F;
      4'd9:    s = 8'h6F;
      default: s = 8'h00;
    endcase
    return SEG_ACTIVE_LOW ? ~s : s;
  endfunction

  // Timekeeping: set mode freezes the prescaler, so a coincident tick is dropped.
  always_comb begin
    cnt_d = cnt_q;
    hh_d  = hh_q;
    mm_d  = mm_q;
    ss_d  = ss_q;
    if (set_mode) begin
      cnt_d = '0;
      ss_d  = 8'h00;
      if (inc_hour) hh_d = bcd_inc(hh_q, 8'h23);
      if (inc_min)  mm_d = bcd_inc(mm_q, 8'h59);
    end else if (cnt_q == CntLast) begin
      cnt_d = '0;
      ss_d  = bcd_inc(ss_q, 8'h59);
      if (ss_q == 8'h59) begin
        mm_d = bcd_inc(mm_q, 8'h59);
        if (mm_q == 8'h59) hh_d = bcd_inc(hh_q, 8'h23);
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    snap    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (dirty_q) begin
          snap       = 1'b1;
          frame_d[0] = seg(hh_q[7:4]);
          frame_d[1] = seg(hh_q[3:0]);
          frame_d[2] = Dash;
          frame_d[3] = seg(mm_q[7:4]);
          frame_d[4] = seg(mm_q[3:0]);
          frame_d[5] = Dash;
          frame_d[6] = seg(ss_q[7:4]);
          frame_d[7] = seg(ss_q[3:0]);
          frame_d[8] = mode_q ? 8'h1B : 8'h00;
          idx_d      = 4'd0;
          state_d    = StWrite;
        end
      end
      StWrite: begin
        if (!master_waitrequest) begin
          if (idx_q == 4'd8) state_d = StIdle;
          else               idx_d   = idx_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    // A change in the same cycle as a snapshot must still schedule another frame.
    dirty_d = (dirty_q & ~snap) | ({hh_d, mm_d, ss_d} != {hh_q, mm_q, ss_q}) |
              (set_mode != mode_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      hh_q    <= 8'h00;
      mm_q    <= 8'h00;
      ss_q    <= 8'h00;
      mode_q  <= 1'b0;
      dirty_q <= 1'b1;
      state_q <= StIdle;
      idx_q   <= 4'd0;
      frame_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      hh_q    <= hh_d;
      mm_q    <= mm_d;
      ss_q    <= ss_d;
      mode_q  <= set_mode;
      dirty_q <= dirty_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
    end
  end

  assign master_write     = (state_q == StWrite);
  assign busy             = (state_q == StWrite);
  assign master_address   = idx_q;
  assign master_writedata = frame_q[idx_q];
  assign time_bcd         = {hh_q, mm_q, ss_q};

endmodule

// File: tb/tb_watch_time_writer.sv
// Randomized scoreboard bench for watch_time_writer: a seconds-of-day reference model
// predicts time_bcd, busy and every expected write beat.
module tb_watch_time_writer;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        set_mode = 1'b0;
  logic        inc_hour = 1'b0;
  logic        inc_min = 1'b0;
  logic        master_waitrequest = 1'b0;
  logic [3:0]  master_address;
  logic        master_write;
  logic [7:0]  master_writedata;
  logic        busy;
  logic [23:0] time_bcd;

  int n_cmp = 0;
  int n_bad = 0;

  watch_time_writer #(.TICKS_PER_SEC(T), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .set_mode           (set_mode),
    .inc_hour           (inc_hour),
    .inc_min            (inc_min),
    .master_address     (master_address),
    .master_write       (master_write),
    .master_writedata   (master_writedata),
    .master_waitrequest (master_waitrequest),
    .busy               (busy),
    .time_bcd           (time_bcd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } beat_t;

  beat_t exp_q[$];
  logic [7:0] lut [10];
  int m_t, m_pres, m_rem;
  bit m_mode, m_dirty;
  bit rand_wait = 0;
  bit track_roll = 0, seen_2359 = 0, seen_wrap = 0;

  initial begin
    lut[0] = 8'h3F; lut[1] = 8'h06; lut[2] = 8'h5B; lut[3] = 8'h4F; lut[4] = 8'h66;
    lut[5] = 8'h6D; lut[6] = 8'h7D; lut[7] = 8'h07; lut[8] = 8'h7F; lut[9] = 8'h6F;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [23:0] bcd24(input int t);
    int h, m, s;
    h = t / 3600; m = (t / 60) % 60; s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [7:0] lit(input int d);
    return ~lut[d];
  endfunction

  task automatic push_frame(input int t, input bit mode);
    logic [7:0] b [9];
    int h, m, s;
    h = t / 3600; m = (t / 60) % 60; s = t % 60;
    b[0] = lit(h / 10); b[1] = lit(h % 10); b[2] = ~8'h40;
    b[3] = lit(m / 10); b[4] = lit(m % 10); b[5] = ~8'h40;
    b[6] = lit(s / 10); b[7] = lit(s % 10); b[8] = mode ? 8'h1B : 8'h00;
    for (int i = 0; i < 9; i++) exp_q.push_back('{a: 4'(i), d: b[i]});
  endtask

  // Reference model: time as seconds of day, frames as whole nine-beat transactions.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_t = 0; m_pres = 0; m_mode = 0; m_dirty = 1; m_rem = 0;
      exp_q.delete();
    end else begin : step
      int old_t, h, m;
      bit tick, chg;
      old_t = m_t;
      tick  = !set_mode && (m_pres == T - 1);
      if (set_mode) begin
        m_pres = 0;
        h = m_t / 3600; m = (m_t / 60) % 60;
        if (inc_hour) h = (h + 1) % 24;
        if (inc_min)  m = (m + 1) % 60;
        m_t = h * 3600 + m * 60;
      end else begin
        m_pres = (m_pres + 1) % T;
        if (tick) m_t = (m_t + 1) % 86400;
      end
      chg = (m_t != old_t) || (set_mode != m_mode);
      if (m_rem == 0) begin
        if (m_dirty) begin
          push_frame(old_t, m_mode);
          m_rem = 9;
          m_dirty = 0;
        end
      end else if (!master_waitrequest) begin
        m_rem--;
      end
      m_dirty = m_dirty | chg;
      m_mode  = set_mode;
    end
  end

  bit hold_pend = 0;
  logic [3:0] hold_a;
  logic [7:0] hold_d;

  always @(negedge clk) begin
    if (!reset_n) begin
      check("reset_write", master_write, 0);
      check("reset_busy", busy, 0);
      check("reset_time", time_bcd, 0);
      hold_pend = 0;
    end else begin
      check("time_bcd", time_bcd, bcd24(m_t));
      check("busy", busy, m_rem > 0);
      if (track_roll) begin
        if (time_bcd == 24'h235959) seen_2359 = 1;
        if (seen_2359 && time_bcd == 24'h000000) seen_wrap = 1;
      end
      if (hold_pend) begin
        check("hold_write", master_write, 1);
        check("hold_addr", master_address, hold_a);
        check("hold_data", master_writedata, hold_d);
      end
      hold_pend = 0;
      if (master_write) begin
        if (master_waitrequest) begin
          hold_pend = 1; hold_a = master_address; hold_d = master_writedata;
        end else if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL beat_unexpected: got addr %0d data %h, expected no beat",
                   master_address, master_writedata);
        end else begin : pop
          beat_t b;
          b = exp_q.pop_front();
          check("beat_addr", master_address, b.a);
          check("beat_data", master_writedata, b.d);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_wait) master_waitrequest = ($urandom_range(0, 3) == 0);
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse(input bit h, input bit m);
    inc_hour = h; inc_min = m;
    cyc(1);
    inc_hour = 0; inc_min = 0;
    cyc(1);
  endtask

  task automatic wait_beat(input int a, output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (master_write && master_address == 4'(a)) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_addr%0d: got no beat, expected one within 200 cycles", a);
    end
  endtask

  initial begin : stim
    bit ok;
    int n;
    cyc(3);
    reset_n = 1;
    cyc(40);

    // Set mode, combined increment, exit
    set_mode = 1; cyc(15);
    pulse(1, 1); cyc(15);
    set_mode = 0; cyc(20);

    // Directed stall on address 4
    wait_beat(3, ok);
    @(posedge clk); #1;
    master_waitrequest = 1; cyc(3);
    master_waitrequest = 0; cyc(20);

    // Rollover through 23:59:59
    set_mode = 1; cyc(2);
    n = (23 - m_t / 3600 + 24) % 24;
    repeat (n) pulse(1, 0);
    n = (59 - (m_t / 60) % 60 + 60) % 60;
    repeat (n) pulse(0, 1);
    cyc(12);
    track_roll = 1; rand_wait = 1;
    set_mode = 0; cyc(59 * T + T + 40);
    track_roll = 0;
    check("rollover_seen_235959", seen_2359, 1);
    check("rollover_wrapped", seen_wrap, 1);

    // Random set-mode toggles, increments and stalls
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 39) == 0) set_mode = ~set_mode;
      inc_hour = set_mode && ($urandom_range(0, 5) == 0);
      inc_min  = set_mode && ($urandom_range(0, 5) == 0);
      cyc(1);
    end
    inc_hour = 0; inc_min = 0; set_mode = 0;
    rand_wait = 0; master_waitrequest = 0;
    cyc(10);

    // Reset during beat 5
    wait_beat(5, ok);
    #1 reset_n = 0;
    #1 check("reset_drops_write", master_write, 0);
    @(posedge clk); #1;
    cyc(2);
    reset_n = 1;
    cyc(30);

    // Freeze time and drain
    set_mode = 1;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (!busy && !m_dirty && m_rem == 0) break;
    end
    cyc(2);
    check("drained_queue", exp_q.size(), 0);
    check("final_idle", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
